// File: rtl/pc_update_unit.sv
// Program-counter register with stall freeze and a one-entry redirect buffer
// that holds a branch/jump target resolved while the cache is busy.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic [31:0] BRANCH_OFFSET,
    input  logic        JUMP,
    input  logic        BRANCH_EQ,
    input  logic        BRANCH_NE,
    input  logic        ZERO,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        REDIRECT_PENDING,
    output logic [31:0] INSTR_COUNT
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] tgt_r;
    logic [31:0] tgt_s;
    logic        pend_r;
    logic        pend_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic        take_s;

    // Next-PC arithmetic and the branch decision
    always_comb begin
        pc_plus4_s = pc_r + PC_STEP;
        target_s   = pc_plus4_s + BRANCH_OFFSET;
        take_s     = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
    end

    // Next-state and next-register values for RUN/HOLD
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        tgt_s   = tgt_r;
        pend_s  = pend_r;
        cnt_s   = cnt_r;
        case (state_r)
            RUN: begin
                if (BUSYWAIT) begin
                    if (take_s) begin
                        tgt_s   = target_s;
                        state_s = HOLD;
                        pend_s  = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    pc_s  = take_s ? target_s : pc_plus4_s;
                    cnt_s = cnt_r + 32'd1;
                end
            end
            HOLD: begin
                // A decision seen on the release edge belongs to the instruction
                // that is already being redirected, so it is dropped.
                if (!BUSYWAIT) begin
                    pc_s    = tgt_r;
                    cnt_s   = cnt_r + 32'd1;
                    state_s = RUN;
                    pend_s  = 1'b0;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = RUN;
                pend_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= RUN;
            pc_r    <= RESET_PC;
            tgt_r   <= 32'h0000_0000;
            pend_r  <= 1'b0;
            cnt_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            tgt_r   <= tgt_s;
            pend_r  <= pend_s;
            cnt_r   <= cnt_s;
        end
    end

    assign PC               = pc_r;
    assign PC_PLUS4         = pc_plus4_s;
    assign REDIRECT_PENDING = pend_r;
    assign INSTR_COUNT      = cnt_r;

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench: a behavioural model pushes expected state per edge into
// a scoreboard queue that is popped and compared after each rising edge.
module tb_pc_update_unit;

    logic        CLK;
    logic        RESET;
    logic        BUSYWAIT;
    logic [31:0] BRANCH_OFFSET;
    logic        JUMP;
    logic        BRANCH_EQ;
    logic        BRANCH_NE;
    logic        ZERO;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        REDIRECT_PENDING;
    logic [31:0] INSTR_COUNT;

    pc_update_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .BUSYWAIT        (BUSYWAIT),
        .BRANCH_OFFSET   (BRANCH_OFFSET),
        .JUMP            (JUMP),
        .BRANCH_EQ       (BRANCH_EQ),
        .BRANCH_NE       (BRANCH_NE),
        .ZERO            (ZERO),
        .PC              (PC),
        .PC_PLUS4        (PC_PLUS4),
        .REDIRECT_PENDING(REDIRECT_PENDING),
        .INSTR_COUNT     (INSTR_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic [31:0] cnt;
        logic [31:0] plus4;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;

    logic [31:0] m_pc;
    logic        m_hold;
    logic [31:0] m_tgt;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, push expectation, then compare after the edge
    task automatic cycle(input logic rst, input logic busy, input logic [31:0] off,
                         input logic j, input logic beq, input logic bne, input logic z);
        exp_t        e;
        logic        take;
        logic [31:0] tgt;
        RESET         = rst;
        BUSYWAIT      = busy;
        BRANCH_OFFSET = off;
        JUMP          = j;
        BRANCH_EQ     = beq;
        BRANCH_NE     = bne;
        ZERO          = z;
        take = j | (beq & z) | (bne & ~z);
        tgt  = m_pc + 32'd4 + off;
        if (!rst) begin
            m_pc = 32'h0; m_hold = 1'b0; m_tgt = 32'h0; m_cnt = 32'h0;
        end else if (m_hold) begin
            if (!busy) begin
                m_pc = m_tgt; m_cnt = m_cnt + 32'd1; m_hold = 1'b0;
            end
        end else if (busy) begin
            if (take) begin
                m_tgt = tgt; m_hold = 1'b1;
            end
        end else begin
            m_pc  = take ? tgt : m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
        e.pc = m_pc; e.pend = m_hold; e.cnt = m_cnt; e.plus4 = m_pc + 32'd4;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("pc", PC, e.pc);
            check("pending", {31'd0, REDIRECT_PENDING}, {31'd0, e.pend});
            check("count", INSTR_COUNT, e.cnt);
            check("pc_plus4", PC_PLUS4, e.plus4);
        end
    endtask

    task automatic idle(input logic busy);
        cycle(1'b1, busy, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0;
        m_pc = 32'h0; m_hold = 1'b0; m_tgt = 32'h0; m_cnt = 32'h0;
        RESET = 1'b0; BUSYWAIT = 1'b0; BRANCH_OFFSET = 32'h0;
        JUMP = 1'b0; BRANCH_EQ = 1'b0; BRANCH_NE = 1'b0; ZERO = 1'b0;
        @(negedge CLK);

        // Reset held with stall and jump asserted
        cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_pc", PC, 32'h0);
        check("rst_pend", {31'd0, REDIRECT_PENDING}, 32'd0);
        check("rst_cnt", INSTR_COUNT, 32'd0);
        idle(1'b0); check("seq_pc1", PC, 32'h4);
        idle(1'b0); check("seq_pc2", PC, 32'h8);
        idle(1'b0); check("seq_pc3", PC, 32'hC);
        check("seq_cnt", INSTR_COUNT, 32'd3);

        // Conditional branches
        idle(1'b0); check("at_10", PC, 32'h10);
        cycle(1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 1'b1);
        check("beq_taken", PC, 32'hC);
        idle(1'b0);
        cycle(1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 1'b0);
        check("beq_not_taken", PC, 32'h14);
        cycle(1'b1, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 1'b0);
        check("jump_back", PC, 32'h10);
        cycle(1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bne_taken", PC, 32'h34);
        cycle(1'b1, 1'b0, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
        check("at_40", PC, 32'h40);

        // Redirect captured during a stall, offset changes ignored while held
        cycle(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stall_pc", PC, 32'h40);
        check("stall_pend", {31'd0, REDIRECT_PENDING}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stall_hold_pc", PC, 32'h40);
        idle(1'b0);
        check("redirect_pc", PC, 32'h144);
        check("redirect_pend", {31'd0, REDIRECT_PENDING}, 32'd0);

        // Target 0x200 latched, then a jump on the release edge is dropped
        cycle(1'b1, 1'b1, 32'h0000_00B8, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        check("release_ignore", PC, 32'h200);
        idle(1'b0);
        check("after_release", PC, 32'h204);

        // Wrap-around via negative offset and sequential overflow
        cycle(1'b1, 1'b0, 32'hFFFF_FE00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("at_8", PC, 32'h8);
        cycle(1'b1, 1'b0, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("neg_wrap", PC, 32'hFFFF_FFFC);
        check("plus4_wrap", PC_PLUS4, 32'h0);
        idle(1'b0);
        check("seq_wrap", PC, 32'h0);

        // Reset while a redirect is pending discards it
        cycle(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_pend", {31'd0, REDIRECT_PENDING}, 32'd1);
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midhold_rst_pc", PC, 32'h0);
        check("midhold_rst_pend", {31'd0, REDIRECT_PENDING}, 32'd0);
        idle(1'b1);
        check("rst_release_busy", PC, 32'h0);
        idle(1'b0);
        check("post_rst_pc", PC, 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1), $urandom(),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter stage directly downstream of the sign-extend/shift stage.
- Consumes the 32-bit sign-extended, x4 branch/jump offset and computes the next PC (PC+4 or PC+4+offset).
- Holds the PC in a register and freezes it while the memory/cache hierarchy asserts BUSYWAIT.
- Captures a branch/jump decision that resolves during a stall in a one-entry redirect buffer, so the redirect is applied exactly once when the stall releases.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset (asserted when 0, sampled on CLK rising edge).
- BUSYWAIT  input  1  stall request from the instruction/data cache; 1 = hold PC.
- BRANCH_OFFSET  input  32  sign-extended, left-shifted-by-2 offset from the sign-extend/shift stage.
- JUMP  input  1  unconditional jump for the current instruction.
- BRANCH_EQ  input  1  current instruction is beq.
- BRANCH_NE  input  1  current instruction is bne.
- ZERO  input  1  ALU zero flag for the current instruction.
- PC  output  32  registered program counter, drives the instruction cache address.
- PC_PLUS4  output  32  combinational PC + PC_STEP.
- REDIRECT_PENDING  output  1  registered; 1 while a latched redirect waits for the stall to clear.
- INSTR_COUNT  output  32  registered count of PC advances since reset.

Behaviour:
- Combinational terms:
  - PC_PLUS4 = PC + PC_STEP, modulo 2^32.
  - TARGET = PC_PLUS4 + BRANCH_OFFSET, modulo 2^32; no overflow detection; negative offsets wrap naturally.
  - TAKE = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO).
- State machine: RUN, HOLD. Internal register TGT_Q (32 bits).
- Reset, when RESET == 0 at a rising edge:
  - PC = RESET_PC; state = RUN; REDIRECT_PENDING = 0; TGT_Q = 0; INSTR_COUNT = 0.
  - Reset has priority over every other input, including mid-stall and in HOLD; a pending redirect is discarded.
- RUN, BUSYWAIT == 1:
  - PC holds; INSTR_COUNT holds.
  - If TAKE, then TGT_Q <= TARGET, state -> HOLD, REDIRECT_PENDING <= 1.
  - If not TAKE, stay in RUN.
- RUN, BUSYWAIT == 0:
  - PC <= TAKE ? TARGET : PC_PLUS4.
  - INSTR_COUNT <= INSTR_COUNT + 1.
- HOLD, BUSYWAIT == 1:
  - PC, TGT_Q and INSTR_COUNT hold.
  - Control inputs are ignored; TGT_Q is not overwritten.
- HOLD, BUSYWAIT == 0:
  - PC <= TGT_Q; INSTR_COUNT +1; state -> RUN; REDIRECT_PENDING <= 0.
  - TAKE on this edge is ignored because it belongs to the already-redirected instruction.
- Latency:
  - Non-stalled: new PC is visible one cycle after the decision edge.
  - Stalled redirect: applied on the first edge with BUSYWAIT == 0.
- Boundary conditions:
  - JUMP together with BRANCH_EQ/BRANCH_NE is legal; TAKE is the OR of the terms.
  - PC = 32'hFFFF_FFFC with no branch wraps to 32'h0000_0000.
  - INSTR_COUNT wraps from 32'hFFFF_FFFF to 0.
  - BUSYWAIT asserted in the cycle RESET is released: PC remains RESET_PC until BUSYWAIT drops.
- No combinational path from any input to PC, REDIRECT_PENDING or INSTR_COUNT.
- PC_PLUS4 depends only on PC.

Test Plan:
- Reset: hold RESET=0 for 2 edges with BUSYWAIT=1 and JUMP=1 -> PC=0, REDIRECT_PENDING=0, INSTR_COUNT=0; release reset with all controls 0 for 3 edges -> PC=4, 8, 12; INSTR_COUNT=3.
- Taken branch: PC=0x10, BRANCH_EQ=1, ZERO=1, BRANCH_OFFSET=0xFFFF_FFF8 (-8) -> next PC=0x0C. Same case with ZERO=0 -> next PC=0x14. BRANCH_NE=1, ZERO=0, offset=0x20 -> next PC=0x34.
- Stalled redirect: PC=0x40, BUSYWAIT=1, JUMP=1, offset=0x100 -> PC stays 0x40 and REDIRECT_PENDING=1 after that edge. Then offset changes to 0x8 while stalled for 3 cycles -> PC stays 0x40. Drop BUSYWAIT -> PC=0x144, REDIRECT_PENDING=0, INSTR_COUNT +1.
- Ignore-on-release: in HOLD with TGT_Q=0x200, release BUSYWAIT while JUMP=1 with offset=0x40 -> PC=0x200, not 0x244; next edge with controls 0 -> PC=0x204.
- Wrap-around: PC=0xFFFF_FFFC, no branch -> PC=0x0000_0000. PC=0x8, JUMP=1, offset=0xFFFF_FFF0 -> PC=0xFFFF_FFFC.
- Reset mid-HOLD: REDIRECT_PENDING=1 and BUSYWAIT=1, assert RESET=0 for one edge -> PC=RESET_PC, REDIRECT_PENDING=0; after release with BUSYWAIT=0 -> PC=4, old target never applied.
